// File: rtl/sample_loader_mc.sv
// sample_loader_mc: multi-channel ADC sample loader writing a circular
// pre/post-trigger buffer into the second port of the sample RAM, with a
// start-to-stop range counter and trigger-address capture.
// Optional build macro SAMPLE_LOADER_DECIM_EN adds a decim[3:0] input that
// thins RAM writes to one every decim+1 clocks.
module sample_loader_mc #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 1,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned CNT_W  = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     start,
  input  logic                     stop,
  input  logic [NUM_CH*DATA_W-1:0] adc_data,
  input  logic [ADDR_W-1:0]        pre_len,
  input  logic [ADDR_W-1:0]        post_len,
`ifdef SAMPLE_LOADER_DECIM_EN
  input  logic [3:0]               decim,
`endif
  output logic [ADDR_W-1:0]        avm_address,
  output logic                     avm_chipselect,
  output logic                     avm_write,
  output logic [NUM_CH*DATA_W-1:0] avm_writedata,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        trig_addr,
  output logic [CNT_W-1:0]         range_count,
  output logic                     range_valid
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [CNT_W-1:0]  ONE_C = 1;

  state_t              r_state;
  state_t              w_state_nx;
  logic                r_stop_s1;
  logic                r_stop_s2;
  logic                r_stop_d;
  logic                w_stop_edge;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_fill_cnt;
  logic [ADDR_W-1:0]   r_post_cnt;
  logic [ADDR_W-1:0]   r_pre_len;
  logic [ADDR_W-1:0]   r_post_len;
  logic                w_wr_en;
  logic                w_latch;
  logic                w_trig_cap;
  logic                w_slot;
  logic                w_trig;
  logic                w_hold;
  logic                w_in_write;
  logic                w_range_act;

  assign w_stop_edge = r_stop_s2 & ~r_stop_d;
  assign w_in_write  = (r_state == ST_PRE) || (r_state == ST_ARMED) || (r_state == ST_POST);
  assign w_range_act = (r_state == ST_PRE) || (r_state == ST_ARMED);

`ifdef SAMPLE_LOADER_DECIM_EN
  logic [3:0] r_decim;
  logic [3:0] r_div;
  logic       r_stop_pend;

  // A stop edge seen between write slots is held until the next slot; the
  // range counter is frozen from the edge itself, not from the slot.
  assign w_slot = (r_div == 4'd0);
  assign w_trig = w_stop_edge | r_stop_pend;
  assign w_hold = r_stop_pend;

  // Write-slot divider and pending-stop flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_decim     <= '0;
      r_div       <= '0;
      r_stop_pend <= 1'b0;
    end else if (w_latch) begin
      r_decim     <= decim;
      r_div       <= '0;
      r_stop_pend <= 1'b0;
    end else if (w_in_write) begin
      r_div       <= (r_div == r_decim) ? 4'd0 : r_div + 4'd1;
      r_stop_pend <= (r_state == ST_ARMED) && !w_slot && w_trig;
    end else begin
      r_stop_pend <= 1'b0;
    end
  end
`else
  assign w_slot = 1'b1;
  assign w_trig = w_stop_edge;
  assign w_hold = 1'b0;
`endif

  // Stop comparator: two-flop synchroniser plus rising-edge history flop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stop_s1 <= 1'b0;
      r_stop_s2 <= 1'b0;
      r_stop_d  <= 1'b0;
    end else begin
      r_stop_s1 <= stop;
      r_stop_s2 <= r_stop_s1;
      r_stop_d  <= r_stop_s2;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next-state and per-cycle write/latch/trigger decisions
  always_comb begin
    w_state_nx = r_state;
    w_wr_en    = 1'b0;
    w_latch    = 1'b0;
    w_trig_cap = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          w_state_nx = ST_PRE;
          w_latch    = 1'b1;
        end
      end
      ST_PRE: begin
        if (r_pre_len == '0) begin
          w_state_nx = ST_ARMED;
        end else if (w_slot) begin
          w_wr_en = 1'b1;
          if (r_fill_cnt == r_pre_len - ONE_A) w_state_nx = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_slot) begin
          w_wr_en = 1'b1;
          if (w_trig) begin
            w_trig_cap = 1'b1;
            w_state_nx = (r_post_len == '0) ? ST_DONE : ST_POST;
          end
        end
      end
      ST_POST: begin
        if (w_slot) begin
          w_wr_en = 1'b1;
          if (r_post_cnt == r_post_len - ONE_A) w_state_nx = ST_DONE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // RAM write port, pointers, trigger capture, status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      trig_addr      <= '0;
      r_wr_ptr       <= '0;
      r_fill_cnt     <= '0;
      r_post_cnt     <= '0;
      r_pre_len      <= '0;
      r_post_len     <= '0;
    end else begin
      avm_write      <= w_wr_en;
      avm_chipselect <= w_wr_en;
      busy           <= (w_state_nx == ST_PRE) || (w_state_nx == ST_ARMED) ||
                        (w_state_nx == ST_POST);
      done           <= (w_state_nx == ST_DONE);
      if (w_latch) begin
        r_pre_len  <= pre_len;
        r_post_len <= post_len;
        r_wr_ptr   <= '0;
        r_fill_cnt <= '0;
        r_post_cnt <= '0;
      end else if (w_wr_en) begin
        avm_address   <= r_wr_ptr;
        avm_writedata <= adc_data;
        r_wr_ptr      <= r_wr_ptr + ONE_A;
        if (r_state == ST_PRE)  r_fill_cnt <= r_fill_cnt + ONE_A;
        if (r_state == ST_POST) r_post_cnt <= r_post_cnt + ONE_A;
      end
      if (w_trig_cap) begin
        trig_addr  <= r_wr_ptr;
        r_post_cnt <= '0;
      end
    end
  end

  // Range counter: start clears/validates, counts clocks, freezes at stop
  always_ff @(posedge clk) begin
    if (reset) begin
      range_count <= '0;
      range_valid <= 1'b0;
    end else if (w_latch) begin
      range_count <= '0;
      range_valid <= 1'b0;
    end else if (w_range_act && !w_hold) begin
      if (start) begin
        range_count <= '0;
        range_valid <= 1'b1;
      end else if (range_valid && (range_count != '1)) begin
        range_count <= range_count + ONE_C;
      end
    end
  end

endmodule
